// File: rtl/vco_datapath_nch.sv
// Multi-channel ring-oscillator counter datapath: wrap-safe deltas, differential or
// single-ended sampling, integrate-and-dump over DECIM samples, saturated output words.
module vco_datapath_nch #(
  parameter int N_CH     = 2,
  parameter int CNT_BITS = 9,
  parameter int DECIM    = 8,
  parameter int OUT_BITS = 12
) (
  input  logic                         CLK_24M,
  input  logic                         reset,
  input  logic                         enable_sampling_3M,
  input  logic                         mode_diff,
  input  logic [N_CH*CNT_BITS-1:0]     counter_p,
  input  logic [N_CH*CNT_BITS-1:0]     counter_n,
  output logic [N_CH*OUT_BITS-1:0]     channel_output,
  output logic                         out_valid,
  output logic [N_CH-1:0]              sat_flag
);

  localparam int K_BITS = $clog2(DECIM);
  localparam int S_BITS = CNT_BITS + 1;
  localparam int A_BITS = S_BITS + K_BITS;
  localparam int W_BITS = (A_BITS > OUT_BITS) ? A_BITS : OUT_BITS;
  localparam logic signed [W_BITS-1:0] MAX_W = W_BITS'((2 ** (OUT_BITS - 1)) - 1);
  localparam logic signed [W_BITS-1:0] MIN_W = ~MAX_W;
  localparam logic [K_BITS-1:0] K_LAST = K_BITS'(DECIM - 1);

  typedef logic [N_CH-1:0][CNT_BITS-1:0] cnt_arr_t;
  typedef logic [N_CH-1:0][A_BITS-1:0]   acc_arr_t;
  typedef logic [N_CH-1:0][OUT_BITS-1:0] out_arr_t;

  cnt_arr_t          cur_p_q, cur_p_d, cur_n_q, cur_n_d;
  cnt_arr_t          prev_p_q, prev_p_d, prev_n_q, prev_n_d;
  acc_arr_t          acc_q, acc_d, sum_q, sum_d;
  out_arr_t          chan_out_q, chan_out_d;
  logic [N_CH-1:0]   sat_q, sat_d;
  logic [K_BITS-1:0] k_q, k_d;
  logic              v1_q, v1_d, v2_q, v2_d;
  logic              out_valid_q, out_valid_d;
  logic              primed_q, primed_d;
  logic              mode_q, mode_d;

  always_comb begin : comb_next
    logic [CNT_BITS-1:0]      dp, dn;
    logic signed [S_BITS-1:0] samp;
    logic [A_BITS-1:0]        acc_nx;
    logic signed [W_BITS-1:0] sum_w;
    logic                     mode_use;

    cur_p_d     = cur_p_q;
    cur_n_d     = cur_n_q;
    prev_p_d    = prev_p_q;
    prev_n_d    = prev_n_q;
    acc_d       = acc_q;
    sum_d       = sum_q;
    chan_out_d  = chan_out_q;
    sat_d       = sat_q;
    k_d         = k_q;
    primed_d    = primed_q;
    mode_d      = mode_q;
    v2_d        = 1'b0;
    dp          = '0;
    dn          = '0;
    samp        = '0;
    acc_nx      = '0;
    sum_w       = '0;
    // Mode is only picked up at frame start so a frame never mixes modes.
    mode_use    = (k_q == '0) ? mode_diff : mode_q;

    v1_d = enable_sampling_3M;
    if (enable_sampling_3M) begin
      cur_p_d = counter_p;
      cur_n_d = counter_n;
    end

    if (v1_q) begin
      prev_p_d = cur_p_q;
      prev_n_d = cur_n_q;
      if (!primed_q) begin
        primed_d = 1'b1;
      end else begin
        mode_d = mode_use;
        v2_d   = (k_q == K_LAST);
        k_d    = (k_q == K_LAST) ? '0 : k_q + K_BITS'(1);
        for (int c = 0; c < N_CH; c++) begin
          // Modular subtraction tolerates one counter wrap between samples.
          dp     = cur_p_q[c] - prev_p_q[c];
          dn     = cur_n_q[c] - prev_n_q[c];
          samp   = mode_use ? ($signed({1'b0, dp}) - $signed({1'b0, dn}))
                            : $signed({1'b0, dp});
          acc_nx = acc_q[c] + A_BITS'(samp);
          if (k_q == K_LAST) begin
            sum_d[c] = acc_nx;
            acc_d[c] = '0;
          end else begin
            acc_d[c] = acc_nx;
          end
        end
      end
    end

    out_valid_d = v2_q;
    if (v2_q) begin
      for (int c = 0; c < N_CH; c++) begin
        sum_w = W_BITS'($signed(sum_q[c]));
        if (sum_w > MAX_W) begin
          chan_out_d[c] = OUT_BITS'(MAX_W);
          sat_d[c]      = 1'b1;
        end else if (sum_w < MIN_W) begin
          chan_out_d[c] = OUT_BITS'(MIN_W);
          sat_d[c]      = 1'b1;
        end else begin
          chan_out_d[c] = OUT_BITS'(sum_w);
          sat_d[c]      = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLK_24M) begin
    if (reset) begin
      cur_p_q     <= '0;
      cur_n_q     <= '0;
      prev_p_q    <= '0;
      prev_n_q    <= '0;
      acc_q       <= '0;
      sum_q       <= '0;
      chan_out_q  <= '0;
      sat_q       <= '0;
      k_q         <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      primed_q    <= 1'b0;
      mode_q      <= 1'b1;
    end else begin
      cur_p_q     <= cur_p_d;
      cur_n_q     <= cur_n_d;
      prev_p_q    <= prev_p_d;
      prev_n_q    <= prev_n_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      chan_out_q  <= chan_out_d;
      sat_q       <= sat_d;
      k_q         <= k_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      out_valid_q <= out_valid_d;
      primed_q    <= primed_d;
      mode_q      <= mode_d;
    end
  end

  assign channel_output = chan_out_q;
  assign out_valid      = out_valid_q;
  assign sat_flag       = sat_q;

endmodule

// File: tb/tb_vco_datapath_nch.sv
// Bench for vco_datapath_nch: two instances (12-bit and 6-bit outputs) share stimulus and
// are checked every cycle against a frame-level arithmetic model.
module tb_vco_datapath_nch;
  localparam int NC   = 2;
  localparam int CB   = 9;
  localparam int DC   = 8;
  localparam int MASK = (1 << CB) - 1;

  logic              clk = 1'b0;
  logic              reset, en, md;
  logic [NC*CB-1:0]  cp, cn;
  logic [NC*12-1:0]  out12;
  logic [NC*6-1:0]   out6;
  logic              v12, v6;
  logic [NC-1:0]     s12, s6;

  vco_datapath_nch #(.N_CH(NC), .CNT_BITS(CB), .DECIM(DC), .OUT_BITS(12)) dut (
    .CLK_24M(clk), .reset(reset), .enable_sampling_3M(en), .mode_diff(md),
    .counter_p(cp), .counter_n(cn), .channel_output(out12), .out_valid(v12), .sat_flag(s12));

  vco_datapath_nch #(.N_CH(NC), .CNT_BITS(CB), .DECIM(DC), .OUT_BITS(6)) dut6 (
    .CLK_24M(clk), .reset(reset), .enable_sampling_3M(en), .mode_diff(md),
    .counter_p(cp), .counter_n(cn), .channel_output(out6), .out_valid(v6), .sat_flag(s6));

  always #5 clk = ~clk;

  typedef struct {int t; int s0; int s1;} exp_s;

  int   total, bad, cyc;
  int   p_abs[NC], n_abs[NC];
  int   m_prev_p[NC], m_prev_n[NC], m_acc[NC], m_k;
  bit   m_primed, m_mode;
  exp_s q[$];
  int   hold12[NC], hold6[NC];
  bit   hsat12[NC], hsat6[NC];

  function automatic int sat_to(input int v, input int w, output bit f);
    int lim;
    lim = 1 << (w - 1);
    f = 1'b0;
    if (v > lim - 1) begin f = 1'b1; return lim - 1; end
    if (v < -lim) begin f = 1'b1; return -lim; end
    return v;
  endfunction

  task automatic tick();
    bit   ev, f;
    exp_s e;
    int   a12, a6;
    @(posedge clk);
    cyc++;
    #1;
    ev = (q.size() > 0) && (q[0].t == cyc);
    total++;
    if (v12 !== ev || v6 !== ev) begin
      bad++;
      $display("FAIL out_valid cyc=%0d got=%b/%b expected=%b", cyc, v12, v6, ev);
    end
    if (ev) begin
      e = q.pop_front();
      hold12[0] = sat_to(e.s0, 12, f); hsat12[0] = f;
      hold12[1] = sat_to(e.s1, 12, f); hsat12[1] = f;
      hold6[0]  = sat_to(e.s0, 6, f);  hsat6[0]  = f;
      hold6[1]  = sat_to(e.s1, 6, f);  hsat6[1]  = f;
    end
    for (int c = 0; c < NC; c++) begin
      a12 = int'($signed(out12[c*12 +: 12]));
      a6  = int'($signed(out6[c*6 +: 6]));
      total++;
      if (a12 !== hold12[c] || s12[c] !== hsat12[c] || a6 !== hold6[c] || s6[c] !== hsat6[c]) begin
        bad++;
        $display("FAIL word cyc=%0d ch=%0d got=%0d/%b,%0d/%b expected=%0d/%b,%0d/%b",
                 cyc, c, a12, s12[c], a6, s6[c], hold12[c], hsat12[c], hold6[c], hsat6[c]);
      end
    end
  endtask

  task automatic do_enable(input int ip0, input int in0, input int ip1, input int in1,
                           input bit mode, input int gap);
    int   ip[NC], inn[NC];
    int   d_p, d_n;
    exp_s e;
    ip[0] = ip0; inn[0] = in0; ip[1] = ip1; inn[1] = in1;
    for (int c = 0; c < NC; c++) begin
      p_abs[c] += ip[c];
      n_abs[c] += inn[c];
      cp[c*CB +: CB] = CB'(p_abs[c] & MASK);
      cn[c*CB +: CB] = CB'(n_abs[c] & MASK);
    end
    md = mode;
    en = 1'b1;
    if (!m_primed) begin
      m_primed = 1'b1;
    end else begin
      if (m_k == 0) m_mode = mode;
      for (int c = 0; c < NC; c++) begin
        d_p = ((p_abs[c] & MASK) - m_prev_p[c]) & MASK;
        d_n = ((n_abs[c] & MASK) - m_prev_n[c]) & MASK;
        m_acc[c] += m_mode ? (d_p - d_n) : d_p;
      end
      m_k++;
      if (m_k == DC) begin
        e.t = cyc + 3; e.s0 = m_acc[0]; e.s1 = m_acc[1];
        q.push_back(e);
        m_acc[0] = 0; m_acc[1] = 0; m_k = 0;
      end
    end
    for (int c = 0; c < NC; c++) begin
      m_prev_p[c] = p_abs[c] & MASK;
      m_prev_n[c] = n_abs[c] & MASK;
    end
    tick();
    en = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    en = 1'b0;
    m_primed = 1'b0; m_k = 0; m_mode = 1'b1;
    q.delete();
    for (int c = 0; c < NC; c++) begin
      m_acc[c] = 0; hold12[c] = 0; hold6[c] = 0; hsat12[c] = 1'b0; hsat6[c] = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      en = (i % 2 == 0);
      tick();
    end
    reset = 1'b0;
    en = 1'b0;
  endtask

  task automatic drain();
    repeat (4) tick();
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (out12 !== '0 || out6 !== '0 || v12 !== 1'b0 || s12 !== '0 || s6 !== '0) begin
      bad++;
      $display("FAIL reset out=%h/%h valid=%b sat=%b/%b expected all zero", out12, out6, v12, s12, s6);
    end
    for (int i = 0; i < 1 + DC; i++) do_enable(5, 3, 7, 2, 1'b1, 1);
    drain();
  endtask

  task automatic test_const_rate();
    do_reset();
    for (int i = 0; i < 1 + 3 * DC; i++) do_enable(20, 12, 12, 20, 1'b1, $urandom_range(3, 1));
    drain();
    total++;
    if (int'($signed(out12[11:0])) !== 64 || int'($signed(out12[23:12])) !== -64 || s12 !== 2'b00) begin
      bad++;
      $display("FAIL const_rate got=%0d,%0d sat=%b expected=64,-64 sat=00",
               int'($signed(out12[11:0])), int'($signed(out12[23:12])), s12);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    p_abs[0] = 468;
    for (int i = 0; i < 1 + DC; i++) do_enable(16, 0, 0, 0, 1'b1, 1);
    drain();
    total++;
    if (int'($signed(out12[11:0])) !== 128 || int'($signed(out12[23:12])) !== 0) begin
      bad++;
      $display("FAIL wrap got=%0d,%0d expected=128,0",
               int'($signed(out12[11:0])), int'($signed(out12[23:12])));
    end
  endtask

  task automatic test_mode_switch();
    do_reset();
    do_enable(20, 12, 12, 20, 1'b1, 1);
    for (int i = 1; i <= DC; i++) do_enable(20, 12, 12, 20, (i < 3), $urandom_range(3, 1));
    drain();
    total++;
    if (int'($signed(out12[11:0])) !== 64 || int'($signed(out12[23:12])) !== -64) begin
      bad++;
      $display("FAIL mode_hold got=%0d,%0d expected=64,-64",
               int'($signed(out12[11:0])), int'($signed(out12[23:12])));
    end
    for (int i = 0; i < DC; i++) do_enable(20, 12, 12, 20, 1'b0, $urandom_range(3, 1));
    drain();
    total++;
    if (int'($signed(out12[11:0])) !== 160 || int'($signed(out12[23:12])) !== 96) begin
      bad++;
      $display("FAIL mode_single got=%0d,%0d expected=160,96",
               int'($signed(out12[11:0])), int'($signed(out12[23:12])));
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 1 + DC; i++) do_enable(40, 0, 0, 0, 1'b1, 1);
    drain();
    total++;
    if (int'($signed(out6[5:0])) !== 31 || s6[0] !== 1'b1 ||
        int'($signed(out12[11:0])) !== 320 || s12[0] !== 1'b0) begin
      bad++;
      $display("FAIL sat_pos got=%0d/%b,%0d/%b expected=31/1,320/0",
               int'($signed(out6[5:0])), s6[0], int'($signed(out12[11:0])), s12[0]);
    end
    for (int i = 0; i < DC; i++) do_enable(0, 40, 0, 0, 1'b1, 1);
    drain();
    total++;
    if (int'($signed(out6[5:0])) !== -32 || s6[0] !== 1'b1 || int'($signed(out12[11:0])) !== -320) begin
      bad++;
      $display("FAIL sat_neg got=%0d/%b,%0d expected=-32/1,-320",
               int'($signed(out6[5:0])), s6[0], int'($signed(out12[11:0])));
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    for (int i = 0; i < 5; i++) do_enable(30, 1, 1, 30, 1'b1, 1);
    do_reset();
    for (int i = 0; i < 1 + DC; i++) do_enable(20, 12, 12, 20, 1'b1, 1);
    drain();
    total++;
    if (int'($signed(out12[11:0])) !== 64 || int'($signed(out12[23:12])) !== -64) begin
      bad++;
      $display("FAIL reset_midframe got=%0d,%0d expected=64,-64",
               int'($signed(out12[11:0])), int'($signed(out12[23:12])));
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 1 + 3 * DC; i++)
      do_enable($urandom_range(511, 0), $urandom_range(511, 0),
                $urandom_range(511, 0), $urandom_range(511, 0), 1'b1, 0);
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 6 * DC; i++)
      do_enable($urandom_range(511, 0), $urandom_range(511, 0),
                $urandom_range(511, 0), $urandom_range(511, 0),
                1'($urandom_range(1, 0)), $urandom_range(3, 1));
    drain();
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    reset = 1'b1; en = 1'b0; md = 1'b1; cp = '0; cn = '0;
    for (int c = 0; c < NC; c++) begin
      p_abs[c] = 0; n_abs[c] = 0; m_prev_p[c] = 0; m_prev_n[c] = 0;
    end
    test_reset();
    test_const_rate();
    test_wrap();
    test_mode_switch();
    test_saturation();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
